// File: rtl/mips_dmem_responder.sv
// Data-memory target for a single-cycle MIPS core: word RAM below the
// MMIO page, and at 0xFFFF_xxxx a timer plus a TX FIFO drained over a
// valid/ready stream. Loads are combinational; all state moves on posedge.
//
// Stream handshake: a word transfers on a rising edge where tx_valid and
// tx_ready are both 1. tx_valid/tx_data come straight from registers, so
// they change only at clock edges. The head is held while tx_ready is 0.
module mips_dmem_responder #(
  parameter int RAM_AW     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] OCC_ONE  = CW'(1);
  localparam logic [CW-1:0] OCC_FULL = CW'(FIFO_DEPTH);

  // Register offsets, in words within the MMIO page.
  localparam logic [13:0] OFF_COUNT  = 14'd0;
  localparam logic [13:0] OFF_CMP    = 14'd1;
  localparam logic [13:0] OFF_STATUS = 14'd2;
  localparam logic [13:0] OFF_CTRL   = 14'd3;
  localparam logic [13:0] OFF_TXDATA = 14'd4;

  // Storage (never reset).
  logic [31:0] ram_mem  [2**RAM_AW];
  logic [31:0] fifo_mem [FIFO_DEPTH];

  // Architectural registers.
  logic [31:0]   count_q, count_d;
  logic [31:0]   cmp_q, cmp_d;
  logic          ten_q, ten_d;
  logic          irqen_q, irqen_d;
  logic          match_q, match_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;

  // Decode.
  logic              mmio_sel;
  logic [13:0]       reg_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_we;
  logic              wr_count, wr_cmp, wr_status, wr_ctrl, push_try;
  logic              unused_addr_lsbs;

  assign mmio_sel  = (memaddr[31:16] == 16'hFFFF);
  assign reg_off   = memaddr[15:2];
  assign ram_idx   = memaddr[RAM_AW+1:2];
  assign ram_we    = memwrite & ~mmio_sel;
  assign wr_count  = memwrite & mmio_sel & (reg_off == OFF_COUNT);
  assign wr_cmp    = memwrite & mmio_sel & (reg_off == OFF_CMP);
  assign wr_status = memwrite & mmio_sel & (reg_off == OFF_STATUS);
  assign wr_ctrl   = memwrite & mmio_sel & (reg_off == OFF_CTRL);
  assign push_try  = memwrite & mmio_sel & (reg_off == OFF_TXDATA);
  // Byte-offset bits are ignored: every access is a full word.
  assign unused_addr_lsbs = ^memaddr[1:0];

  // FIFO flags and handshake.
  logic fifo_full, fifo_empty, pop, push_ok, match_set;

  assign fifo_full  = (occ_q == OCC_FULL);
  assign fifo_empty = (occ_q == '0);
  assign pop        = ~fifo_empty & tx_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // still lands when the consumer is taking the head.
  assign push_ok    = push_try & (~fifo_full | pop);
  assign match_set  = ten_q & (count_q == cmp_q);

  assign tx_valid = ~fifo_empty;
  assign tx_data  = fifo_empty ? 32'h0 : fifo_mem[rd_ptr_q];
  assign irq      = match_q & irqen_q;

  // Next-state for timer, status and FIFO bookkeeping.
  always_comb begin
    count_d  = count_q;
    cmp_d    = cmp_q;
    ten_d    = ten_q;
    irqen_d  = irqen_q;
    match_d  = match_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;

    // A CPU load of COUNT wins over the running increment.
    if (wr_count)   count_d = memwritedata;
    else if (ten_q) count_d = count_q + 32'd1;

    if (wr_cmp) cmp_d = memwritedata;

    if (wr_ctrl) begin
      ten_d   = memwritedata[0];
      irqen_d = memwritedata[1];
    end

    // Sticky flags: a new event beats a write-1-clear in the same cycle.
    if (wr_status && memwritedata[0]) match_d = 1'b0;
    if (match_set)                    match_d = 1'b1;
    if (wr_status && memwritedata[3]) ovf_d = 1'b0;
    if (push_try && !push_ok)         ovf_d = 1'b1;

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  // Register update; reset overrides any write or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= 32'h0;
      cmp_q    <= 32'hFFFF_FFFF;
      ten_q    <= 1'b0;
      irqen_q  <= 1'b0;
      match_q  <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      count_q  <= count_d;
      cmp_q    <= cmp_d;
      ten_q    <= ten_d;
      irqen_q  <= irqen_d;
      match_q  <= match_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // RAM and FIFO storage writes; contents survive reset but a store
  // issued during reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && ram_we)  ram_mem[ram_idx]   <= memwritedata;
    if (!reset && push_ok) fifo_mem[wr_ptr_q] <= memwritedata;
  end

  // Combinational load path.
  logic [31:0] status_word;
  assign status_word = {16'h0, 8'(occ_q), 4'h0, ovf_q, fifo_empty, fifo_full, match_q};

  // Load data mux: RAM below the MMIO page, registers inside it.
  always_comb begin
    memreaddata = 32'h0;
    if (!mmio_sel) begin
      memreaddata = ram_mem[ram_idx];
    end else begin
      case (reg_off)
        OFF_COUNT:  memreaddata = count_q;
        OFF_CMP:    memreaddata = cmp_q;
        OFF_STATUS: memreaddata = status_word;
        OFF_CTRL:   memreaddata = {30'h0, irqen_q, ten_q};
        default:    memreaddata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Testbench for mips_dmem_responder: RAM, timer, TX FIFO and reset.
module tb_mips_dmem_responder;

  localparam logic [31:0] A_COUNT  = 32'hFFFF_0000;
  localparam logic [31:0] A_CMP    = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
  localparam logic [31:0] A_CTRL   = 32'hFFFF_000C;
  localparam logic [31:0] A_TX     = 32'hFFFF_0010;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;
  logic        irq;

  int n_cmp;
  int n_fail;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  mips_dmem_responder #(.RAM_AW(8), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .memaddr      (memaddr),
    .memwritedata (memwritedata),
    .memreaddata  (memreaddata),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .irq          (irq)
  );

  // Clock and time limit.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "time limit");
  end

  // Stream scoreboard: every handshake seen at negedge pops one expected word.
  always @(negedge clk) begin
    if (!reset && tx_valid && tx_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_pop_unexpected: got %h expected no word", tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (tx_data !== mon_exp) begin
          n_fail++;
          $display("FAIL tx_data_order: got %h expected %h", tx_data, mon_exp);
        end
      end
    end
  end

  // Driver tasks. Inputs change at posedge+1; reads settle 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    memaddr = a;
    #1;
    d = memreaddata;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memaddr      = a;
    memwritedata = d;
    memwrite     = 1'b1;
    step();
    memwrite = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input bit accepted);
    if (accepted) exp_q.push_back(d);
    wr(A_TX, d);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    rd(A_COUNT, v);
    n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL rst_count: got %h expected %h", v, 32'h0); end
    rd(A_CMP, v);
    n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_cmp: got %h expected %h", v, 32'hFFFF_FFFF); end
    rd(A_STATUS, v);
    n_cmp++; if (v !== 32'h4) begin n_fail++; $display("FAIL rst_status: got %h expected %h", v, 32'h4); end
    rd(A_CTRL, v);
    n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL rst_ctrl: got %h expected %h", v, 32'h0); end
    n_cmp++; if ({tx_valid, irq} !== 2'b00) begin n_fail++; $display("FAIL rst_valid_irq: got %b expected 00", {tx_valid, irq}); end
    n_cmp++; if (tx_data !== 32'h0) begin n_fail++; $display("FAIL rst_tx_data: got %h expected 0", tx_data); end
  endtask

  task automatic test_ram();
    logic [31:0] v;
    logic [31:0] model [4];
    wr(32'h10, 32'h1111_1111);
    memaddr      = 32'h10;
    memwritedata = 32'hDEAD_BEEF;
    memwrite     = 1'b1;
    #1;
    n_cmp++; if (memreaddata !== 32'h1111_1111) begin n_fail++; $display("FAIL ram_same_cycle: got %h expected %h", memreaddata, 32'h1111_1111); end
    step();
    memwrite = 1'b0;
    rd(32'h10, v);
    n_cmp++; if (v !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_readback: got %h expected %h", v, 32'hDEAD_BEEF); end
    rd(32'h410, v);
    n_cmp++; if (v !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_alias: got %h expected %h", v, 32'hDEAD_BEEF); end
    rd(32'hFFFE_0010, v);
    n_cmp++; if (v !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_below_mmio: got %h expected %h", v, 32'hDEAD_BEEF); end
    for (int i = 0; i < 4; i++) begin
      model[i] = $urandom_range(32'hFFFF_FFFF, 0);
      wr(32'h20 + 32'(4 * i), model[i]);
    end
    for (int i = 0; i < 4; i++) begin
      rd(32'h20 + 32'(4 * i), v);
      n_cmp++; if (v !== model[i]) begin n_fail++; $display("FAIL ram_random_%0d: got %h expected %h", i, v, model[i]); end
    end
    rd(32'hFFFF_0020, v);
    n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL mmio_unmapped: got %h expected 0", v); end
    rd(A_TX, v);
    n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL txdata_read: got %h expected 0", v); end
  endtask

  task automatic test_timer();
    logic [31:0] v;
    wr(A_CMP, 32'd5);
    wr(A_CTRL, 32'hFFFF_FFFF);
    for (int k = 0; k <= 5; k++) begin
      rd(A_COUNT, v);
      n_cmp++; if (v !== 32'(k)) begin n_fail++; $display("FAIL timer_count_%0d: got %h expected %h", k, v, 32'(k)); end
      n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL timer_irq_early_%0d: got %b expected 0", k, irq); end
      step();
    end
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL timer_irq_rise: got %b expected 1", irq); end
    rd(A_STATUS, v);
    n_cmp++; if (v !== 32'h5) begin n_fail++; $display("FAIL timer_match: got %h expected %h", v, 32'h5); end
    rd(A_CTRL, v);
    n_cmp++; if (v !== 32'h3) begin n_fail++; $display("FAIL ctrl_mask: got %h expected %h", v, 32'h3); end
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, v);
    n_cmp++; if (v !== 32'h4) begin n_fail++; $display("FAIL match_clear: got %h expected %h", v, 32'h4); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b expected 0", irq); end
    // Reload COUNT to CMP, then clear in the very cycle the match fires.
    wr(A_COUNT, 32'd5);
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, v);
    n_cmp++; if (v !== 32'h5) begin n_fail++; $display("FAIL set_beats_clear: got %h expected %h", v, 32'h5); end
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL set_beats_clear_irq: got %b expected 1", irq); end
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    wr(A_COUNT, 32'hFFFF_FFFE);
    rd(A_COUNT, v);
    n_cmp++; if (v !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL wrap_load: got %h expected %h", v, 32'hFFFF_FFFE); end
    step();
    rd(A_COUNT, v);
    n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_max: got %h expected %h", v, 32'hFFFF_FFFF); end
    step();
    rd(A_COUNT, v);
    n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL wrap_zero: got %h expected 0", v); end
    // Stop the timer (this cycle still increments to 1) and clear sticky flags.
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h9);
    rd(A_COUNT, v);
    n_cmp++; if (v !== 32'h1) begin n_fail++; $display("FAIL timer_stopped: got %h expected %h", v, 32'h1); end
    rd(A_STATUS, v);
    n_cmp++; if (v !== 32'h4) begin n_fail++; $display("FAIL status_idle: got %h expected %h", v, 32'h4); end
  endtask

  task automatic test_fifo_fill();
    logic [31:0] v;
    tx_ready     = 1'b0;
    memaddr      = A_TX;
    memwritedata = 32'd1;
    memwrite     = 1'b1;
    #1;
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL push_not_early: got %b expected 0", tx_valid); end
    exp_q.push_back(32'd1);
    step();
    memwrite = 1'b0;
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 32'd1) begin n_fail++; $display("FAIL push_next_cycle: got %b/%h expected 1/%h", tx_valid, tx_data, 32'd1); end
    for (int i = 2; i <= 4; i++) push(32'(i), 1'b1);
    rd(A_STATUS, v);
    n_cmp++; if (v !== 32'h0402) begin n_fail++; $display("FAIL fifo_full: got %h expected %h", v, 32'h0402); end
    push(32'd5, 1'b0);
    rd(A_STATUS, v);
    n_cmp++; if (v !== 32'h040A) begin n_fail++; $display("FAIL fifo_ovf: got %h expected %h", v, 32'h040A); end
    n_cmp++; if (tx_data !== 32'd1) begin n_fail++; $display("FAIL head_stable: got %h expected %h", tx_data, 32'd1); end
    tx_ready = 1'b1;
    repeat (4) step();
    tx_ready = 1'b0;
    n_cmp++; if (tx_valid !== 1'b0 || tx_data !== 32'h0) begin n_fail++; $display("FAIL drained: got %b/%h expected 0/0", tx_valid, tx_data); end
    rd(A_STATUS, v);
    n_cmp++; if (v !== 32'h000C) begin n_fail++; $display("FAIL drained_status: got %h expected %h", v, 32'h000C); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL drain_count: got %0d left expected 0", exp_q.size()); end
    wr(A_STATUS, 32'h8);
    rd(A_STATUS, v);
    n_cmp++; if (v !== 32'h0004) begin n_fail++; $display("FAIL ovf_clear: got %h expected %h", v, 32'h0004); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    tx_ready = 1'b0;
    for (int i = 5; i <= 8; i++) push(32'(i), 1'b1);
    // Full FIFO: push and pop in the same cycle.
    exp_q.push_back(32'd9);
    memaddr      = A_TX;
    memwritedata = 32'd9;
    memwrite     = 1'b1;
    tx_ready     = 1'b1;
    step();
    memwrite = 1'b0;
    tx_ready = 1'b0;
    rd(A_STATUS, v);
    n_cmp++; if (v !== 32'h0402) begin n_fail++; $display("FAIL full_push_pop: got %h expected %h", v, 32'h0402); end
    n_cmp++; if (tx_data !== 32'd6) begin n_fail++; $display("FAIL full_push_pop_head: got %h expected %h", tx_data, 32'd6); end
    tx_ready = 1'b1;
    repeat (4) step();
    tx_ready = 1'b0;
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain_count: got %0d left expected 0", exp_q.size()); end
    rd(A_STATUS, v);
    n_cmp++; if (v !== 32'h0004) begin n_fail++; $display("FAIL b2b_empty: got %h expected %h", v, 32'h0004); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] v;
    tx_ready = 1'b0;
    push(32'hA1, 1'b1);
    push(32'hA2, 1'b1);
    wr(A_CMP, 32'd3);
    wr(A_COUNT, 32'd0);
    wr(A_CTRL, 32'h3);
    repeat (6) step();
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b expected 1", irq); end
    memaddr      = A_TX;
    memwritedata = 32'h77;
    memwrite     = 1'b1;
    reset        = 1'b1;
    step();
    reset    = 1'b0;
    memwrite = 1'b0;
    exp_q.delete();
    rd(A_COUNT, v);
    n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL mid_rst_count: got %h expected 0", v); end
    rd(A_CMP, v);
    n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mid_rst_cmp: got %h expected %h", v, 32'hFFFF_FFFF); end
    rd(A_STATUS, v);
    n_cmp++; if (v !== 32'h4) begin n_fail++; $display("FAIL mid_rst_status: got %h expected %h", v, 32'h4); end
    n_cmp++; if ({tx_valid, irq} !== 2'b00) begin n_fail++; $display("FAIL mid_rst_valid_irq: got %b expected 00", {tx_valid, irq}); end
    n_cmp++; if (tx_data !== 32'h0) begin n_fail++; $display("FAIL mid_rst_tx_data: got %h expected 0", tx_data); end
  endtask

  // Test sequence and final report.
  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    reset        = 1'b1;
    memwrite     = 1'b0;
    memaddr      = 32'h0;
    memwritedata = 32'h0;
    tx_ready     = 1'b0;
    test_reset();
    test_ram();
    test_timer();
    test_wrap();
    test_fifo_fill();
    test_back_to_back();
    test_reset_mid_op();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
